decode_ctrl: RTL and testbench

Decode-stage controller for the pipelined RV32I core. It decodes the instruction in D, combinationally drives `imm_src_d` and `imm_d` to the immediate extender, and detects load-use hazards. It also owns the ID/EX control pipeline register, including its stall bubbles and branch/jump flush. The extender, register file and E-stage datapath consume its outputs; the fetch stage consumes its stall/flush outputs.

---
 rtl/decode_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_decode_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// RV32I decode-stage controller: instruction decode, load-use hazard detection
// and the ID/EX control pipeline register with stall bubbles and branch flush.
module decode_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic        pc_src_e,
    output logic [2:0]  imm_src_d,
    output logic [24:0] imm_d,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        valid_e,
    output logic        illegal_e,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic        alu_src_e,
    output logic [1:0]  result_src_e,
    output logic [2:0]  alu_ctrl_e,
    output logic [2:0]  funct3_e,
    output logic [4:0]  rd_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;

    assign opcode = instr_d[6:0];
    assign rd_d   = instr_d[11:7];
    assign funct3 = instr_d[14:12];
    assign rs1_d  = instr_d[19:15];
    assign rs2_d  = instr_d[24:20];
    assign funct7 = instr_d[31:25];
    assign imm_d  = instr_d[31:7];

    // Returns {legal, alu_ctrl}; sub_sel picks sub for funct3 000, srl_ok gates funct3 101.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub_sel,
                                           input logic srl_ok);
        logic [3:0] r;
        r = 4'b0000;
        case (f3)
            3'b000:  r = {1'b1, (sub_sel ? 3'b001 : 3'b000)};
            3'b111:  r = 4'b1010;
            3'b110:  r = 4'b1011;
            3'b100:  r = 4'b1100;
            3'b010:  r = 4'b1101;
            3'b001:  r = 4'b1110;
            3'b101:  r = srl_ok ? 4'b1111 : 4'b0000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    logic       legal;
    logic [2:0] imm_src;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
    logic       use_rs1;
    logic       use_rs2;
    logic [3:0] alu_r;
    logic [3:0] alu_i;

    assign alu_r = alu_dec(funct3, funct7[5], ~funct7[5]);
    assign alu_i = alu_dec(funct3, 1'b0, (funct7 == 7'd0));

    always_comb begin
        legal      = 1'b0;
        imm_src    = 3'b000;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        result_src = 2'b00;
        alu_ctrl   = 3'b000;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (opcode)
            OP_LW: if (funct3 == 3'b010) begin
                legal = 1'b1; alu_src = 1'b1; reg_write = 1'b1;
                result_src = 2'b01; use_rs1 = 1'b1;
            end
            OP_SW: if (funct3 == 3'b010) begin
                legal = 1'b1; imm_src = 3'b001; alu_src = 1'b1; mem_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_R: if (alu_r[3]) begin
                legal = 1'b1; reg_write = 1'b1; alu_ctrl = alu_r[2:0];
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_I: if (alu_i[3]) begin
                legal = 1'b1; alu_src = 1'b1; reg_write = 1'b1; alu_ctrl = alu_i[2:0];
                use_rs1 = 1'b1;
            end
            OP_BR: if (funct3 == 3'b000 || funct3 == 3'b001) begin
                legal = 1'b1; imm_src = 3'b101; branch = 1'b1; alu_ctrl = 3'b001;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_JAL: begin
                legal = 1'b1; imm_src = 3'b110; jump = 1'b1; reg_write = 1'b1;
                result_src = 2'b10;
            end
            OP_JALR: if (funct3 == 3'b000) begin
                legal = 1'b1; jump = 1'b1; alu_src = 1'b1; reg_write = 1'b1;
                result_src = 2'b10; use_rs1 = 1'b1;
            end
            OP_LUI: begin
                legal = 1'b1; imm_src = 3'b010; reg_write = 1'b1; result_src = 2'b11;
            end
            default: legal = 1'b0;
        endcase
    end

    assign imm_src_d = imm_src;

    // A load in E whose destination feeds a used source in D must wait one cycle.
    logic lduse;
    logic bubble;

    assign lduse = valid_e && (result_src_e == 2'b01) && (rd_e != 5'd0) &&
                   ((use_rs1 && (rs1_d == rd_e)) || (use_rs2 && (rs2_d == rd_e)));
    assign stall_f = lduse & ~pc_src_e;
    assign stall_d = lduse & ~pc_src_e;
    assign flush_d = pc_src_e;
    assign bubble  = lduse | pc_src_e;

    // ID/EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            valid_e      <= 1'b0;
            illegal_e    <= 1'b0;
            reg_write_e  <= 1'b0;
            mem_write_e  <= 1'b0;
            branch_e     <= 1'b0;
            jump_e       <= 1'b0;
            alu_src_e    <= 1'b0;
            result_src_e <= 2'b00;
            alu_ctrl_e   <= 3'b000;
            funct3_e     <= 3'b000;
            rd_e         <= 5'd0;
            rs1_e        <= 5'd0;
            rs2_e        <= 5'd0;
        end else begin
            valid_e      <= 1'b1;
            illegal_e    <= ~legal;
            reg_write_e  <= reg_write;
            mem_write_e  <= mem_write;
            branch_e     <= branch;
            jump_e       <= jump;
            alu_src_e    <= alu_src;
            result_src_e <= result_src;
            alu_ctrl_e   <= alu_ctrl;
            funct3_e     <= funct3;
            rd_e         <= rd_d;
            rs1_e        <= rs1_d;
            rs2_e        <= rs2_d;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Table-driven bench for decode_ctrl: per-step decode/hazard checks before the
// edge, E-register checks after it, plus hand-written reset sequences.
module tb_decode_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        pc_src_e;
    logic [2:0]  imm_src_d;
    logic [24:0] imm_d;
    logic        stall_f, stall_d, flush_d;
    logic        valid_e, illegal_e;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_ctrl_e, funct3_e;
    logic [4:0]  rd_e, rs1_e, rs2_e;

    decode_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_src_e(pc_src_e),
        .imm_src_d(imm_src_d), .imm_d(imm_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .valid_e(valid_e), .illegal_e(illegal_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .branch_e(branch_e), .jump_e(jump_e), .alu_src_e(alu_src_e),
        .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e),
        .funct3_e(funct3_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        pc_src;
        logic [2:0]  imm_src;
        logic        stall;
        logic        flush;
        logic        valid;
        logic        illegal;
        logic [4:0]  ctrl;   // {reg_write, mem_write, branch, jump, alu_src}
        logic [1:0]  res;
        logic [2:0]  alu;
        logic [4:0]  rd;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    int checks;
    int failures;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_e_zero(input string tag);
        chk({tag, " valid_e"}, {31'd0, valid_e}, 32'd0);
        chk({tag, " illegal_e"}, {31'd0, illegal_e}, 32'd0);
        chk({tag, " ctrl"}, {27'd0, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e}, 32'd0);
        chk({tag, " result_src_e"}, {30'd0, result_src_e}, 32'd0);
        chk({tag, " rd_e"}, {27'd0, rd_e}, 32'd0);
        chk({tag, " rs1_e"}, {27'd0, rs1_e}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //                instr         pc    imm     st    fl    v     il    ctrl      res    alu     rd
        vecs[0]  = '{32'hFFF08293, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10001, 2'b00, 3'b000, 5'd5};  // addi x5,x1,-1
        vecs[1]  = '{32'h0000A283, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10001, 2'b01, 3'b000, 5'd5};  // lw x5,0(x1)
        vecs[2]  = '{32'h00228333, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b00, 3'b000, 5'd0};  // add stalls
        vecs[3]  = '{32'h00228333, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10000, 2'b00, 3'b000, 5'd6};  // add proceeds
        vecs[4]  = '{32'h0000A003, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10001, 2'b01, 3'b000, 5'd0};  // lw x0
        vecs[5]  = '{32'h00200333, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10000, 2'b00, 3'b000, 5'd6};  // add x6,x0,x2
        vecs[6]  = '{32'h0020A423, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01001, 2'b00, 3'b000, 5'd8};  // sw x2,8(x1)
        vecs[7]  = '{32'h0020A423, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 2'b00, 3'b000, 5'd0};  // sw flushed
        vecs[8]  = '{32'h0000A283, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10001, 2'b01, 3'b000, 5'd5};  // lw x5
        vecs[9]  = '{32'h00228333, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 2'b00, 3'b000, 5'd0};  // flush beats lduse
        vecs[10] = '{32'h0000007F, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 2'b00, 3'b000, 5'd0};  // illegal opcode
        vecs[11] = '{32'h402083B3, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10000, 2'b00, 3'b001, 5'd7};  // sub
        vecs[12] = '{32'h00208863, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00100, 2'b00, 3'b001, 5'd16}; // beq
        vecs[13] = '{32'h000000EF, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10010, 2'b10, 3'b000, 5'd1};  // jal x1
        vecs[14] = '{32'h123451B7, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10000, 2'b11, 3'b000, 5'd3};  // lui x3
        vecs[15] = '{32'h4020D0B3, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 2'b00, 3'b000, 5'd1};  // sra illegal
        vecs[16] = '{32'h0030D093, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10001, 2'b00, 3'b111, 5'd1};  // srli
        vecs[17] = '{32'h4030D093, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 2'b00, 3'b000, 5'd1};  // srai illegal
        vecs[18] = '{32'h0020F233, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10000, 2'b00, 3'b010, 5'd4};  // and
        vecs[19] = '{32'h0000A283, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10001, 2'b01, 3'b000, 5'd5};  // lw x5
        vecs[20] = '{32'h0050A023, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b00, 3'b000, 5'd0};  // sw x5 via rs2
        vecs[21] = '{32'h0050A023, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01001, 2'b00, 3'b000, 5'd0};  // sw proceeds
        vecs[22] = '{32'h0000A283, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10001, 2'b01, 3'b000, 5'd5};  // lw x5
        vecs[23] = '{32'h00508313, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10001, 2'b00, 3'b000, 5'd6};  // addi, rs2 field unused

        rst_n    = 1'b0;
        instr_d  = 32'h00000013;
        pc_src_e = 1'b0;
        #2;
        chk_e_zero("init_reset");
        chk("init_reset stall_f", {31'd0, stall_f}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            instr_d  = vecs[i].instr;
            pc_src_e = vecs[i].pc_src;
            #1;
            chk($sformatf("v%0d imm_src_d", i), {29'd0, imm_src_d}, {29'd0, vecs[i].imm_src});
            chk($sformatf("v%0d imm_d", i), {7'd0, imm_d}, {7'd0, vecs[i].instr[31:7]});
            chk($sformatf("v%0d stall_f", i), {31'd0, stall_f}, {31'd0, vecs[i].stall});
            chk($sformatf("v%0d stall_d", i), {31'd0, stall_d}, {31'd0, vecs[i].stall});
            chk($sformatf("v%0d flush_d", i), {31'd0, flush_d}, {31'd0, vecs[i].flush});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid_e", i), {31'd0, valid_e}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d illegal_e", i), {31'd0, illegal_e}, {31'd0, vecs[i].illegal});
            chk($sformatf("v%0d ctrl", i),
                {27'd0, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e}, {27'd0, vecs[i].ctrl});
            chk($sformatf("v%0d result_src_e", i), {30'd0, result_src_e}, {30'd0, vecs[i].res});
            chk($sformatf("v%0d alu_ctrl_e", i), {29'd0, alu_ctrl_e}, {29'd0, vecs[i].alu});
            chk($sformatf("v%0d rd_e", i), {27'd0, rd_e}, {27'd0, vecs[i].rd});
        end

        // Mid-stream asynchronous reset while a load-use stall is pending
        @(negedge clk);
        instr_d  = 32'h0000A283;
        pc_src_e = 1'b0;
        @(posedge clk);
        #1;
        instr_d = 32'h00228333;
        #1;
        chk("pre_reset stall_f", {31'd0, stall_f}, 32'd1);
        chk("pre_reset funct3_e", {29'd0, funct3_e}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk_e_zero("async_reset");
        chk("async_reset stall_f", {31'd0, stall_f}, 32'd0);
        chk("async_reset stall_d", {31'd0, stall_d}, 32'd0);
        pc_src_e = 1'b1;
        #1;
        chk("reset flush_d follows", {31'd0, flush_d}, 32'd1);
        pc_src_e = 1'b0;
        #1;
        chk("reset flush_d low", {31'd0, flush_d}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_reset valid_e", {31'd0, valid_e}, 32'd0);

        // First instruction after reset release decodes normally
        @(negedge clk);
        rst_n   = 1'b1;
        instr_d = 32'hFFF08293;
        #1;
        chk("post_reset imm_d", {7'd0, imm_d}, 32'h01FFE105);
        chk("post_reset imm_src_d", {29'd0, imm_src_d}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_reset valid_e", {31'd0, valid_e}, 32'd1);
        chk("post_reset reg_write_e", {31'd0, reg_write_e}, 32'd1);
        chk("post_reset alu_src_e", {31'd0, alu_src_e}, 32'd1);
        chk("post_reset rd_e", {27'd0, rd_e}, 32'd5);
        chk("post_reset rs1_e", {27'd0, rs1_e}, 32'd1);
        chk("post_reset rs2_e", {27'd0, rs2_e}, 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
